// File: rtl/stim_pkg.sv
// stim_pkg
//   Shared definitions for the stimulus generator: the sweep FSM state
//   encoding and the default operand width / inputB hold length.
package stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_HOLD   = 1;
    // HOLD may be as large as 255, so the hold counter is always 8 bits.
    localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/stim_gen_wrap_counter.sv
// wrap_counter
//   Modulo counter that counts 0..MAX and wraps back to 0. Several
//   instances chain into a multi-digit counter by feeding one stage's
//   wrap into the next stage's en.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset, clears count
//   clr   in   synchronous clear, clears count (overrides en)
//   en    in   advance count by one (modulo MAX+1)
//   count out  current registered count
//   wrap  out  en && count==MAX: this edge takes count back to 0
module wrap_counter #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_max;

    assign at_max = (count_q == MAX);
    assign wrap   = en && at_max;
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = at_max ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stim_gen.sv
// stim_gen
//   Exhaustive operand-pair sweep generator. After start, presents every
//   (inputA, inputB) pair in order, inputB fastest, each inputB value held
//   for HOLD consumed cycles; then raises done until the next start.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset to IDLE, operands to 0
//   start   in   begin a sweep from IDLE or DONE (ignored in RUN)
//   stall   in   downstream not ready; freezes the sweep in RUN
//   inputA  out  slow operand, registered
//   inputB  out  fast operand, registered
//   valid   out  current pair is presented and consumed this cycle
//   done    out  sweep complete, high while in DONE
module stim_gen
    import stim_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HOLD  = DEF_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    output logic [WIDTH-1:0] inputA,
    output logic [WIDTH-1:0] inputB,
    output logic             valid,
    output logic             done
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_MAX = HOLD_CNT_W'(HOLD - 1);

    state_t state_q;
    state_t state_d;

    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic                  hold_wrap;
    logic                  b_wrap;
    logic                  a_wrap;
    logic                  cnt_clr;
    logic                  terminal;

    assign valid = (state_q == RUN) && !stall;
    assign done  = (state_q == DONE);

    // Outside RUN the operands are pinned at 0 so every sweep starts at 0,0.
    assign cnt_clr = (state_q != RUN);

    // The hold check is implied by a_wrap through the enable chain; it is
    // spelled out so the terminal condition reads as all-counters-at-max.
    assign terminal = a_wrap && (hold_cnt == HOLD_MAX);

    wrap_counter #(.W(HOLD_CNT_W), .MAX(HOLD_MAX)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (valid),
        .count (hold_cnt),
        .wrap  (hold_wrap)
    );

    wrap_counter #(.W(WIDTH), .MAX({WIDTH{1'b1}})) u_input_b (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (hold_wrap),
        .count (inputB),
        .wrap  (b_wrap)
    );

    wrap_counter #(.W(WIDTH), .MAX({WIDTH{1'b1}})) u_input_a (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (b_wrap),
        .count (inputA),
        .wrap  (a_wrap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (terminal) state_d = DONE;
            DONE: if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_stim_gen.sv
module tb_stim_gen;

    logic       clk;
    logic       rst, start, stall;
    logic [3:0] a, b;
    logic       valid, done;

    logic       rst_h, start_h, stall_h;
    logic [3:0] a_h, b_h;
    logic       valid_h, done_h;

    int n_vec = 0;
    int n_err = 0;
    int exp_b[7] = '{0, 0, 0, 1, 1, 1, 2};

    stim_gen #(.WIDTH(4), .HOLD(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stall  (stall),
        .inputA (a),
        .inputB (b),
        .valid  (valid),
        .done   (done)
    );

    stim_gen #(.WIDTH(4), .HOLD(3)) dut_h3 (
        .clk    (clk),
        .rst    (rst_h),
        .start  (start_h),
        .stall  (stall_h),
        .inputA (a_h),
        .inputB (b_h),
        .valid  (valid_h),
        .done   (done_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        rst_h = 1'b1; start_h = 1'b0; stall_h = 1'b0;
        tick(2);
        rst = 1'b0;
        rst_h = 1'b0;
        #1;
        check("reset_state", 32'({a, b, valid, done}), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("idle_no_start", 32'({a, b, valid, done}), 32'd0);
        end
        check("h3_idle", 32'({a_h, b_h, valid_h, done_h}), 32'd0);

        // Start and inputB -> inputA carry
        start = 1'b1;
        tick(1);
        start = 1'b0;
        #1;
        check("valid1", 32'({a, b, valid, done}), 32'({4'd0, 4'd0, 1'b1, 1'b0}));
        tick(15);
        check("valid16", 32'({a, b, valid}), 32'({4'd0, 4'd15, 1'b1}));
        tick(1);
        check("valid17", 32'({a, b, valid}), 32'({4'd1, 4'd0, 1'b1}));

        // Stall at (2,5): index 37, currently at index 16
        tick(21);
        check("pre_stall", 32'({a, b, valid}), 32'({4'd2, 4'd5, 1'b1}));
        stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stalled", 32'({a, b, valid, done}), 32'({4'd2, 4'd5, 1'b0, 1'b0}));
            tick(1);
        end
        stall = 1'b0;
        #1;
        check("stall_release", 32'({a, b, valid}), 32'({4'd2, 4'd5, 1'b1}));
        tick(1);
        check("post_stall", 32'({a, b, valid}), 32'({4'd2, 4'd6, 1'b1}));

        // Run to the terminal pair (index 255), currently index 38
        tick(217);
        check("last_pair", 32'({a, b, valid, done}), 32'({4'd15, 4'd15, 1'b1, 1'b0}));
        stall = 1'b1;
        tick(1);
        check("term_stall", 32'({a, b, valid, done}), 32'({4'd15, 4'd15, 1'b0, 1'b0}));
        stall = 1'b0;
        #1;
        check("term_release", 32'({a, b, valid}), 32'({4'd15, 4'd15, 1'b1}));
        tick(1);
        check("done", 32'({a, b, valid, done}), 32'({4'd0, 4'd0, 1'b0, 1'b1}));
        tick(3);
        check("done_hold", 32'({a, b, valid, done}), 32'({4'd0, 4'd0, 1'b0, 1'b1}));
        start = 1'b1;
        tick(1);
        start = 1'b0;
        #1;
        check("restart", 32'({a, b, valid, done}), 32'({4'd0, 4'd0, 1'b1, 1'b0}));

        // Reset mid-run at (7,9), with start also high to show rst wins
        tick(121);
        check("pre_rst", 32'({a, b, valid}), 32'({4'd7, 4'd9, 1'b1}));
        rst = 1'b1;
        start = 1'b1;
        tick(1);
        rst = 1'b0;
        start = 1'b0;
        #1;
        check("mid_rst", 32'({a, b, valid, done}), 32'd0);
        tick(5);
        check("rst_needs_start", 32'({a, b, valid, done}), 32'd0);

        // HOLD=3 instance: inputB held three consumed cycles per value
        start_h = 1'b1;
        tick(1);
        start_h = 1'b0;
        #1;
        for (int i = 0; i < 7; i++) begin
            check("h3_b_seq", 32'({a_h, b_h, valid_h}), 32'({4'd0, 4'(exp_b[i]), 1'b1}));
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
